// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, fetches one word per
// instruction over req/gnt/rvalid, holds it until retired.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   imem_req/addr       fetch request and byte address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   returned instruction word
//   instr, op, funct    latched instruction and its fields
//   instr_valid         instr awaits retirement
//   exec_done           datapath retires instr this cycle
//   branch_taken        with exec_done: take beq target
//   pc, pc_plus4        current address and pc + 4
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        VALID
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] seq_pc;
    logic [31:0] br_off;

    assign seq_pc = pc_q + 32'd4;
    // word offset, sign-extended and scaled to bytes
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt && imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (exec_done) begin
                    pc_d    = branch_taken ? seq_pc + br_off
                                           : seq_pc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = (state_q == VALID);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the single-cycle MIPS core. Holds the program counter, fetches instruction words from an instruction memory over a request/grant/response handshake, and presents the current instruction, with `op` and `funct` split out, to the control unit and datapath. It computes the next PC (sequential or `beq` target) when the datapath retires the current instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request, held until granted.
- `imem_addr`  out  32  fetch byte address, equal to `pc` while `imem_req`=1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is valid and awaiting retirement.
- `exec_done`  in  1  datapath retires the current instruction this cycle.
- `branch_taken`  in  1  sampled with `exec_done`: branch & ALU zero.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational.

## Operation
- FSM states: IDLE, REQ, WAIT, VALID.
- IDLE: entered on reset, left unconditionally to REQ on the next edge. `imem_req`=0.
- REQ: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_gnt`=1 with `imem_rvalid`=1: latch `imem_rdata` into `instr` and go to VALID.
  - On `imem_gnt`=1 alone: go to WAIT.
  - Otherwise stay in REQ.
- WAIT: `imem_req`=0. On `imem_rvalid`=1, latch `imem_rdata` and go to VALID.
- VALID: `instr_valid`=1 and `instr` is held stable. On `exec_done`=1, update `pc` and go to REQ.
  - `branch_taken`=0: `pc` ← `pc + 4`.
  - `branch_taken`=1: `pc` ← `pc + 4 + (sign_extend(instr[15:0]) << 2)`.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. `pc` = 32'hFFFF_FFFC followed by a sequential step gives 0. Branch offsets use the sign of `instr[15]`, and backward targets wrap the same way.
- `pc[1:0]` stays 0 by construction. No alignment check is made.
- Ignored inputs:
  - `imem_rvalid` in IDLE, VALID, or in REQ without `imem_gnt`.
  - `exec_done` outside VALID.
  - `branch_taken` without `exec_done`.
- Reset mid-operation: `reset_n` low in any state forces IDLE immediately. Any outstanding memory response is discarded: after reset, the first response accepted is the one following a new grant.
- Reset values:
  - `pc` = `RESET_PC`, `instr` = 0, `instr_valid` = 0, `imem_req` = 0.
  - `imem_addr` = `RESET_PC`, `op` = 0, `funct` = 0, `pc_plus4` = `RESET_PC + 4`.

## Timing
- All state updates occur on the rising edge of `clk`. Outputs are registered or direct functions of registers; there is no input-to-output combinational path.
- First fetch: `imem_req` rises in the second cycle after `reset_n` deasserts (cycle 0 is IDLE, cycle 1 is REQ).
- With zero-wait memory (`gnt` and `rvalid` in the same cycle as the request):
  - `instr_valid` goes high the cycle after REQ.
  - Sustained throughput is 1 instruction per 2 cycles (VALID, REQ alternating).
- Each extra cycle of grant delay or response delay adds exactly one cycle.
- `instr_valid` falls in the cycle after `exec_done`. `pc` shows the new address in that same cycle.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning 32'h0000_0020 → `imem_req` in cycle 1; `instr_valid` in cycle 2 with `op`=0 and `funct`=6'h20; `pc`=0.
- Three sequential retirements with `branch_taken`=0 → `imem_addr` sequence 0, 4, 8, 12; each `instr_valid` pulse is one cycle wide when `exec_done` is held high.
- Branch: `pc`=32'h40, `instr`=32'h1000_FFFE, `exec_done`=`branch_taken`=1 → next `pc`=32'h3C. Repeat with `branch_taken`=0 → 32'h44.
- Memory stall: `imem_gnt` delayed 2 cycles, then `imem_rvalid` 3 cycles after grant → `imem_req` high for 3 cycles; `instr_valid` rises the cycle after `rvalid`; a spurious `rvalid` before the grant is ignored.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC, one sequential retirement → `pc`=0.
- Reset asserted in WAIT, and the stale `rvalid` arrives after `reset_n` rises → stale word is not latched; `instr`=0; a fresh request is issued to `RESET_PC`.
